automaton_equiv_sequencer: RTL and testbench

- Controller that drives two 1-bit-input DFA blocks (the codebase's Automaton modules, async active-high reset, registered accept output) with one shared stimulus.
- Exhaustively enumerates every binary input string of length 0..MAXLEN, resets both DFAs before each string and compares the accept outputs after the last bit.
- Reports equal/not-equal plus the first counterexample.
- Replaces the free-running assertion-based equivalence harness with a self-sequencing, synthesizable checker.

---
 rtl/automaton_equiv_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_automaton_equiv_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/automaton_equiv_sequencer.sv
// automaton_equiv_sequencer
//   Drives two 1-bit-input DFAs with one shared input stream and checks that they are equivalent.
//   Every binary string of length 0..MAXLEN is tried in order of length, then value. Both DFAs are
//   reset before each string. After the last symbol, the two accept outputs are compared.
//   The result is an equal flag plus the first counterexample found.
//
// Optional feature (macro CONTINUE_ON_MISMATCH_EN):
//   The enumeration always runs to completion. Mismatching strings are counted in mismatch_cnt_o,
//   which saturates at 16'hFFFF. cex_* keep the first mismatch only.
//
// Ports:
//   clk_i          clock, posedge
//   rst_ni         asynchronous active-low reset
//   start_i        begin a run (honoured in idle/done only)
//   dut_rst_o      registered active-high reset to both DFAs
//   dut_in_o       registered shared input bit to both DFAs
//   out1_i/out2_i  accept outputs of DFA 1 / DFA 2
//   busy_o         run in progress
//   done_o         run finished, held until next start
//   equal_o        valid with done_o, 1 = no mismatch
//   cex_len_o      length of first mismatching string
//   cex_bits_o     first mismatching string, bit k = k-th symbol fed
//   mismatch_cnt_o number of mismatching strings (optional feature only)
module automaton_equiv_sequencer #(
   parameter int unsigned MAXLEN = 8,
   parameter int unsigned LENW   = 5
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   output logic              dut_rst_o,
   output logic              dut_in_o,
   input  logic              out1_i,
   input  logic              out2_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              equal_o,
   output logic [LENW-1:0]   cex_len_o,
   output logic [MAXLEN-1:0] cex_bits_o
`ifdef CONTINUE_ON_MISMATCH_EN
   ,
   output logic [15:0]       mismatch_cnt_o
`endif
);

   typedef enum logic [2:0] {StIdle, StRst, StFeed, StCheck, StDone} state_e;

   localparam logic [MAXLEN:0] One = {{MAXLEN{1'b0}}, 1'b1};

   state_e            state_q, state_d;
   logic [LENW-1:0]   len_q, len_d;
   logic [LENW-1:0]   idx_q, idx_d;
   logic [MAXLEN-1:0] pat_q, pat_d;
   logic              dut_rst_q, dut_rst_d;
   logic              dut_in_q, dut_in_d;
   logic              equal_q, equal_d;
   logic [LENW-1:0]   cex_len_q, cex_len_d;
   logic [MAXLEN-1:0] cex_bits_q, cex_bits_d;
`ifdef CONTINUE_ON_MISMATCH_EN
   logic              seen_q, seen_d;
   logic [15:0]       cnt_q, cnt_d;
`endif

   logic [MAXLEN:0]   last_pat_val;
   logic              last_pat;
   logic              last_len;
   logic              mism;
   logic [MAXLEN-1:0] pat_shift;

   // All-ones pattern of the current length marks the last string of this length.
   assign last_pat_val = (One << len_q) - One;
   assign last_pat     = ({1'b0, pat_q} == last_pat_val);
   assign last_len     = (len_q == LENW'(MAXLEN));
   assign mism         = (out1_i != out2_i);

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      idx_d      = idx_q;
      pat_d      = pat_q;
      equal_d    = equal_q;
      cex_len_d  = cex_len_q;
      cex_bits_d = cex_bits_q;
`ifdef CONTINUE_ON_MISMATCH_EN
      seen_d     = seen_q;
      cnt_d      = cnt_q;
`endif
      unique case (state_q)
         StIdle, StDone: begin
            if (start_i) begin
               len_d      = '0;
               pat_d      = '0;
               idx_d      = '0;
               equal_d    = 1'b0;
               cex_len_d  = '0;
               cex_bits_d = '0;
`ifdef CONTINUE_ON_MISMATCH_EN
               seen_d     = 1'b0;
               cnt_d      = '0;
`endif
               state_d    = StRst;
            end
         end
         StRst: begin
            idx_d   = '0;
            state_d = (len_q != '0) ? StFeed : StCheck;
         end
         StFeed: begin
            if (idx_q == len_q - 1'b1) begin
               state_d = StCheck;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         StCheck: begin
            if (last_pat && last_len) begin
`ifdef CONTINUE_ON_MISMATCH_EN
               equal_d = !(seen_q || mism);
`else
               equal_d = 1'b1;
`endif
               state_d = StDone;
            end else if (last_pat) begin
               len_d   = len_q + 1'b1;
               pat_d   = '0;
               state_d = StRst;
            end else begin
               pat_d   = pat_q + 1'b1;
               state_d = StRst;
            end
            if (mism) begin
`ifdef CONTINUE_ON_MISMATCH_EN
               if (!seen_q) begin
                  cex_len_d  = len_q;
                  cex_bits_d = pat_q;
               end
               seen_d = 1'b1;
               if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
`else
               cex_len_d  = len_q;
               cex_bits_d = pat_q;
               equal_d    = 1'b0;
               state_d    = StDone;
`endif
            end
         end
         default: state_d = StIdle;
      endcase

      // DFA controls are registered from the next state. Reset is released only while feeding or
      // checking, and the input is non-zero only while feeding.
      pat_shift = pat_d >> idx_d;
      dut_rst_d = !(state_d == StFeed || state_d == StCheck);
      dut_in_d  = (state_d == StFeed) ? pat_shift[0] : 1'b0;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= StIdle;
         len_q      <= '0;
         idx_q      <= '0;
         pat_q      <= '0;
         dut_rst_q  <= 1'b1;
         dut_in_q   <= 1'b0;
         equal_q    <= 1'b0;
         cex_len_q  <= '0;
         cex_bits_q <= '0;
`ifdef CONTINUE_ON_MISMATCH_EN
         seen_q     <= 1'b0;
         cnt_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         idx_q      <= idx_d;
         pat_q      <= pat_d;
         dut_rst_q  <= dut_rst_d;
         dut_in_q   <= dut_in_d;
         equal_q    <= equal_d;
         cex_len_q  <= cex_len_d;
         cex_bits_q <= cex_bits_d;
`ifdef CONTINUE_ON_MISMATCH_EN
         seen_q     <= seen_d;
         cnt_q      <= cnt_d;
`endif
      end
   end

   assign dut_rst_o  = dut_rst_q;
   assign dut_in_o   = dut_in_q;
   assign busy_o     = (state_q == StRst) || (state_q == StFeed) || (state_q == StCheck);
   assign done_o     = (state_q == StDone);
   assign equal_o    = equal_q;
   assign cex_len_o  = cex_len_q;
   assign cex_bits_o = cex_bits_q;
`ifdef CONTINUE_ON_MISMATCH_EN
   assign mismatch_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_automaton_equiv_sequencer.sv
// Bench for automaton_equiv_sequencer with MAXLEN=3.
// Two "ends-in-1" DFAs and a 3-state variant of the same language are modelled locally.
// The expected result of each run is produced by a string-level reference model.
module tb_automaton_equiv_sequencer;

   localparam int unsigned MAXLEN = 3;
   localparam int unsigned LENW   = 3;
   localparam int          Budget = 300;

   typedef struct {
      int cycles;
      int eq;
      int clen;
      int cbits;
      int cnt;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              start = 1'b0;
   logic              dut_rst, dut_in, out1, out2, busy, done, equal;
   logic [LENW-1:0]   cex_len;
   logic [MAXLEN-1:0] cex_bits;
`ifdef CONTINUE_ON_MISMATCH_EN
   logic [15:0]       mismatch_cnt;
`endif
   int                sel;  // 0: same DFA, 1: 3-state variant, 2: out2 tied low
   int                n_checks = 0;
   int                n_errors = 0;
   exp_t              exp_q[$];

   always #5 clk = ~clk;

   automaton_equiv_sequencer #(
      .MAXLEN(MAXLEN),
      .LENW  (LENW)
   ) u_dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .start_i       (start),
      .dut_rst_o     (dut_rst),
      .dut_in_o      (dut_in),
      .out1_i        (out1),
      .out2_i        (out2),
      .busy_o        (busy),
      .done_o        (done),
      .equal_o       (equal),
      .cex_len_o     (cex_len),
      .cex_bits_o    (cex_bits)
`ifdef CONTINUE_ON_MISMATCH_EN
      ,
      .mismatch_cnt_o(mismatch_cnt)
`endif
   );

   // DFAs with async active-high reset and registered accept output.
   logic       a1_acc, a2_acc, b_acc;
   logic [1:0] b_st, b_nxt;
   assign b_nxt = dut_in ? 2'b11 : 2'b01;
   always_ff @(posedge clk or posedge dut_rst) begin
      if (dut_rst) begin
         a1_acc <= 1'b0;
         a2_acc <= 1'b0;
         b_st   <= 2'b01;
         b_acc  <= 1'b0;
      end else begin
         a1_acc <= dut_in;
         a2_acc <= dut_in;
         b_st   <= b_nxt;
         b_acc  <= (b_nxt == 2'b11);
      end
   end
   assign out1 = a1_acc;
   assign out2 = (sel == 0) ? a2_acc : (sel == 1) ? b_acc : 1'b0;

   task automatic check_eq(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // String-level reference: walks strings in enumeration order, evaluating each DFA on whole strings.
   function automatic exp_t model(input int s);
      exp_t e;
      bit   found = 1'b0;
      bit   stop = 1'b0;
      bit   o1, o2;
      int   st;
      e = '{cycles: 0, eq: 0, clen: 0, cbits: 0, cnt: 0};
      for (int l = 0; l <= int'(MAXLEN) && !stop; l++) begin
         for (int p = 0; p < (1 << l) && !stop; p++) begin
            e.cycles += l + 2;
            o1 = (l > 0) ? p[l-1] : 1'b0;
            st = 1;
            for (int k = 0; k < l; k++) st = p[k] ? 3 : 1;
            o2 = (s == 0) ? o1 : (s == 1) ? (st == 3) : 1'b0;
            if (o1 != o2) begin
               e.cnt++;
               if (!found) begin
                  found   = 1'b1;
                  e.clen  = l;
                  e.cbits = p;
               end
`ifndef CONTINUE_ON_MISMATCH_EN
               stop = 1'b1;
`endif
            end
         end
      end
      e.eq = found ? 0 : 1;
      return e;
   endfunction

   task automatic check_reset_vals(input string pfx);
      check_eq({pfx, "_dut_rst"}, dut_rst, 1);
      check_eq({pfx, "_dut_in"}, dut_in, 0);
      check_eq({pfx, "_busy"}, busy, 0);
      check_eq({pfx, "_done"}, done, 0);
      check_eq({pfx, "_equal"}, equal, 0);
      check_eq({pfx, "_cex_len"}, cex_len, 0);
      check_eq({pfx, "_cex_bits"}, cex_bits, 0);
   endtask

   // Push the expected result, start a run and wait for done.
   // Optionally pulse start mid-run, which must have no effect.
   task automatic run_test(input string tag, input bit mid_pulse);
      exp_t e;
      int   cyc;
      bit   busy_ok;
      exp_q.push_back(model(sel));
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      cyc     = 0;
      busy_ok = 1'b1;
      while (!done && cyc < Budget) begin
         if (!busy) busy_ok = 1'b0;
         start = (mid_pulse && cyc == 20);
         @(posedge clk);
         #1 cyc++;
      end
      start = 1'b0;
      e = exp_q.pop_front();
      check_eq({tag, "_done"}, done, 1);
      check_eq({tag, "_cycles"}, cyc, e.cycles);
      check_eq({tag, "_busy_run"}, busy_ok, 1);
      check_eq({tag, "_busy_end"}, busy, 0);
      check_eq({tag, "_dut_rst"}, dut_rst, 1);
      check_eq({tag, "_equal"}, equal, e.eq);
      check_eq({tag, "_cex_len"}, cex_len, e.clen);
      check_eq({tag, "_cex_bits"}, cex_bits, e.cbits);
`ifdef CONTINUE_ON_MISMATCH_EN
      check_eq({tag, "_mismatch_cnt"}, mismatch_cnt, e.cnt);
`endif
   endtask

   initial begin
      sel = 0;
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 check_reset_vals("reset");
      @(negedge clk) rst_n = 1'b1;

      // Identical DFAs: equal after 64 cycles.
      sel = 0;
      run_test("same", 1'b0);
      check_eq("same_cycles_const", u_dut.done_o ? 64 : 0, model(0).cycles);

      // Different state encoding, same language.
      sel = 1;
      run_test("variant", 1'b0);

      // out2 tied low: first mismatch is "1" (len 1) after 8 cycles in the default build.
      // With CONTINUE_ON_MISMATCH_EN the run takes 64 cycles and counts 1+2+4 = 7 strings ending in 1.
      sel = 2;
      run_test("tied0", 1'b0);

      // Abort during the first feed cycle of a length-2 string (cycles: 2 for L0, 6 for L1, then RST).
      sel = 0;
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      check_eq("abort_in_feed", dut_rst, 0);
      check_eq("abort_busy", busy, 1);
      rst_n = 1'b0;
      #1 check_reset_vals("abort");
      @(negedge clk) rst_n = 1'b1;
      run_test("after_abort", 1'b0);

      // Start while busy is ignored; start in done restarts with the same result.
      run_test("busy_pulse", 1'b1);
      run_test("restart", 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
